// File: rtl/prog_loader.sv
// prog_loader: byte-stream boot loader for instruction memory.
// Stream format: length (16-bit word count, little-endian), then
// count*4 payload bytes packed little-endian into 32-bit words.
// The core is held in reset until the load completes.
// Optional macro PROG_LOADER_CHECKSUM_EN appends a trailing XOR checksum
// byte that must match the payload before the core is released.
module prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH = 2**ADDR_W;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} state_t;
`endif

  state_t        state;
  logic [15:0]   count;
  logic [ADDR_W:0] index;
  logic [1:0]    lane;
  logic [23:0]   word;
  logic [15:0]   len_next;
  logic          last_word;
  logic          xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign len_next  = {byte_data, count[7:0]};
  // index is one bit wider than the address so a full-depth load compares cleanly
  assign last_word = (32'(index) + 32'd1) == 32'(count);
  assign xfer      = byte_valid & byte_ready;

  // Accept bytes in every state that still expects stream input
  always_comb begin
    byte_ready = 1'b0;
    case (state)
      LEN0, LEN1, DATA: byte_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:             byte_ready = 1'b1;
`endif
      default:          byte_ready = 1'b0;
    endcase
  end

  // Loader FSM with registered memory-write and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN0;
      count     <= '0;
      index     <= '0;
      lane      <= '0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN0: begin
          if (xfer) begin
            count[7:0] <= byte_data;
            state      <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            count[15:8] <= byte_data;
            index       <= '0;
            lane        <= '0;
            if (32'(len_next) > DEPTH) begin
              state <= ERR;
              error <= 1'b1;
            end else if (len_next == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word[7:0]   <= byte_data;
              2'd1: word[15:8]  <= byte_data;
              2'd2: word[23:16] <= byte_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= index[ADDR_W-1:0];
                mem_wdata <= {byte_data, word};
                index     <= index + 1'b1;
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state <= CSUM;
`else
                  state    <= DONE;
                  done     <= 1'b1;
                  core_rst <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            if (byte_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (start) begin
            state    <= LEN0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            index    <= '0;
            lane     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        ERR: begin
          if (start) begin
            state <= LEN0;
            error <= 1'b0;
            index <= '0;
            lane  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        default: state <= LEN0;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random payloads checked against a
// stream-level model of which words land at which addresses.
module tb_prog_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  stim[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done, exp_err;
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  always @(posedge clk) cyc++;

  // Log every write strobe seen between edges
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void clear_log();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
  endfunction

  function automatic void push_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = '0;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    stim.push_back(x);
`endif
  endfunction

  // Stream-level reference: what a complete stream should write and end in
  function automatic void model();
    int len;
    logic [7:0] x;
    len = int'(stim[0]) + 256 * int'(stim[1]);
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0; x = '0;
    if (len > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < len; w++) begin
        exp_addr.push_back(w);
        exp_data.push_back({stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
        for (int k = 0; k < 4; k++) x ^= stim[2+4*w+k];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      exp_done = (stim[2+4*len] == x);
      exp_err  = !exp_done;
`else
      exp_done = 1'b1;
`endif
    end
  endfunction

  // Drive stim; returns at the negedge following the last transfer
  task automatic drive(input int gapmax);
    for (int i = 0; i < stim.size(); i++) begin
      int t;
      repeat ($urandom_range(gapmax, 0)) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = stim[i];
      t = 0;
      while (byte_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (byte_ready !== 1'b1) begin
        errors++;
        $display("FAIL drive_ready: byte %0d got byte_ready=%b want 1", i, byte_ready);
        byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got we=%b addr=%0d data=%h want 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({core_rst, done, error, byte_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_status: got core_rst/done/error/ready=%b want 1001",
               {core_rst, done, error, byte_ready});
    end
  endtask

  task automatic test_basic();
    do_reset();
    clear_log();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    push_csum();
    model();
    drive(0);
`ifndef PROG_LOADER_CHECKSUM_EN
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL basic_last_strobe: got mem_we=%b want 1", mem_we);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b core_rst=%b want 1/0", done, core_rst);
    end
    checks++;
    if (wq_addr.size() !== 2) begin
      errors++;
      $display("FAIL basic_count: got %0d writes want 2", wq_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL basic_write%0d: got %0d:%h want %0d:%h", i, wq_addr[i], wq_data[i],
                   exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if (wq_cyc[1] - wq_cyc[0] !== 4) begin
        errors++;
        $display("FAIL basic_spacing: got %0d cycles want 4", wq_cyc[1] - wq_cyc[0]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    clear_log();
    stim = '{8'h41, 8'h00};
    drive(0);
    repeat (3) @(negedge clk);
    checks++;
    if ({error, core_rst, done, byte_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL ovf_state: got error/core_rst/done/ready=%b want 1100",
               {error, core_rst, done, byte_ready});
    end
    checks++;
    if (wq_addr.size() !== 0) begin
      errors++;
      $display("FAIL ovf_writes: got %0d writes want 0", wq_addr.size());
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (byte_ready !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL ovf_restart: got ready=%b error=%b want 1/0", byte_ready, error);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    clear_log();
    stim = '{8'h00, 8'h00};
    push_csum();
    drive(0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || core_rst !== 1'b0 || wq_addr.size() !== 0) begin
      errors++;
      $display("FAIL zero_len: got done=%b core_rst=%b writes=%0d want 1/0/0",
               done, core_rst, wq_addr.size());
    end
  endtask

  task automatic test_rst_midload();
    logic [31:0] w0;
    do_reset();
    clear_log();
    stim = '{8'h03, 8'h00};
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    w0 = {stim[5], stim[4], stim[3], stim[2]};
    drive(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || byte_ready !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got we=%b ready=%b core_rst=%b done=%b want 0/1/1/0",
               mem_we, byte_ready, core_rst, done);
    end
    checks++;
    if (wq_addr.size() !== 1 || wq_data[0] !== w0 || wq_addr[0] !== 0) begin
      errors++;
      $display("FAIL midrst_writes: got %0d writes first=%h want 1 write %h", wq_addr.size(),
               (wq_data.size() > 0) ? wq_data[0] : 32'h0, w0);
    end
    clear_log();
    stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_csum();
    drive(1);
    @(negedge clk);
    checks++;
    if (wq_addr.size() !== 1 || wq_addr[0] !== 0 || wq_data[0] !== 32'hDDCCBBAA || done !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reload: got writes=%0d data=%h done=%b want 1/ddccbbaa/1",
               wq_addr.size(), (wq_data.size() > 0) ? wq_data[0] : 32'h0, done);
    end
  endtask

  task automatic test_full_depth();
    // Restart from DONE left by the previous load
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_restart: got core_rst=%b done=%b ready=%b want 1/0/1",
               core_rst, done, byte_ready);
    end
    clear_log();
    stim = '{8'h40, 8'h00};
    for (int i = 0; i < 4*DEPTH; i++) stim.push_back(8'($urandom));
    push_csum();
    model();
    drive(2);
    @(negedge clk);
    checks++;
    if (wq_addr.size() !== DEPTH) begin
      errors++;
      $display("FAIL full_count: got %0d writes want %0d", wq_addr.size(), DEPTH);
    end else begin
      int bad = 0;
      for (int i = 0; i < DEPTH; i++)
        if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL full_data: got %0d bad words want 0", bad);
      end
    end
    checks++;
    if (done !== exp_done || byte_ready !== 1'b0 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got done=%b ready=%b core_rst=%b want %b/0/0",
               done, byte_ready, core_rst, exp_done);
    end
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || wq_addr.size() !== DEPTH) begin
      errors++;
      $display("FAIL done_ignores_bytes: got done=%b writes=%0d want 1/%0d",
               done, wq_addr.size(), DEPTH);
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      clear_log();
      stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      stim.push_back(pass == 0 ? 8'h44 : 8'h45);
      model();
      drive(0);
      @(negedge clk);
      checks++;
      if (done !== exp_done || error !== exp_err || core_rst !== !exp_done) begin
        errors++;
        $display("FAIL csum_status%0d: got done=%b error=%b core_rst=%b want %b/%b/%b",
                 pass, done, error, core_rst, exp_done, exp_err, !exp_done);
      end
      checks++;
      if (wq_addr.size() !== 1 || wq_data[0] !== 32'h44332211 || wq_addr[0] !== 0) begin
        errors++;
        $display("FAIL csum_write%0d: got writes=%0d data=%h want 1/44332211", pass,
                 wq_addr.size(), (wq_data.size() > 0) ? wq_data[0] : 32'h0);
      end
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_zero_len();
    test_rst_midload();
    test_full_depth();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
